// File: rtl/regfile_cmd_ctrl.sv
// Byte-command master for the system regfile: decodes UART write/read
// commands, strobes the regfile, and returns read data to the UART transmitter.
module regfile_cmd_ctrl #(
   parameter int               WIDTH      = 8,
   parameter int               ADDR_W     = 4,
   parameter logic [WIDTH-1:0] CMD_WR     = 8'hAA,
   parameter logic [WIDTH-1:0] CMD_RD     = 8'hBB,
   parameter int               RD_TIMEOUT = 15
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [WIDTH-1:0]  i_rx_data,
   input  logic              i_rx_valid,
   output logic              o_rf_en_w,
   output logic              o_rf_en_r,
   output logic [ADDR_W-1:0] o_rf_add,
   output logic [WIDTH-1:0]  o_rf_data,
   input  logic [WIDTH-1:0]  i_rf_data,
   input  logic              i_rf_valid,
   output logic [WIDTH-1:0]  o_tx_data,
   output logic              o_tx_valid,
   input  logic              i_tx_busy,
   output logic              o_busy,
   output logic              o_err
);

   localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND} state_t;

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [WIDTH-1:0]  rd_byte, rd_byte_n;
   logic              rf_en_w_n, rf_en_r_n, tx_valid_n, err_n;
   logic [ADDR_W-1:0] rf_add_n;
   logic [WIDTH-1:0]  rf_data_n, tx_data_n;
   logic              addr_ok;

   // Address bytes must not carry bits above the regfile address range.
   assign addr_ok = (i_rx_data[WIDTH-1:ADDR_W] == '0);

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      rd_byte_n  = rd_byte;
      rf_en_w_n  = 1'b0;
      rf_en_r_n  = 1'b0;
      rf_add_n   = o_rf_add;
      rf_data_n  = o_rf_data;
      tx_data_n  = o_tx_data;
      tx_valid_n = 1'b0;
      err_n      = 1'b0;
      case (state)
         IDLE: begin
            if (i_rx_valid) begin
               if (i_rx_data == CMD_WR)      state_n = WR_ADDR;
               else if (i_rx_data == CMD_RD) state_n = RD_ADDR;
               else                          err_n   = 1'b1;
            end
         end
         WR_ADDR: begin
            if (i_rx_valid) begin
               if (addr_ok) begin
                  rf_add_n = i_rx_data[ADDR_W-1:0];
                  state_n  = WR_DATA;
               end else begin
                  err_n   = 1'b1;
                  state_n = IDLE;
               end
            end
         end
         WR_DATA: begin
            if (i_rx_valid) begin
               rf_data_n = i_rx_data;
               rf_en_w_n = 1'b1;
               state_n   = IDLE;
            end
         end
         RD_ADDR: begin
            if (i_rx_valid) begin
               if (addr_ok) begin
                  rf_add_n  = i_rx_data[ADDR_W-1:0];
                  rf_en_r_n = 1'b1;
                  cnt_n     = '0;
                  state_n   = RD_WAIT;
               end else begin
                  err_n   = 1'b1;
                  state_n = IDLE;
               end
            end
         end
         RD_WAIT: begin
            // Read data may already be valid alongside the read strobe.
            if (i_rx_valid) err_n = 1'b1;
            if (i_rf_valid) begin
               rd_byte_n = i_rf_data;
               cnt_n     = '0;
               state_n   = TX_SEND;
            end else if (cnt == CNT_W'(RD_TIMEOUT - 1)) begin
               err_n   = 1'b1;
               cnt_n   = '0;
               state_n = IDLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         TX_SEND: begin
            if (i_rx_valid) err_n = 1'b1;
            if (!i_tx_busy) begin
               tx_valid_n = 1'b1;
               tx_data_n  = rd_byte;
               state_n    = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         cnt        <= '0;
         o_rf_en_w  <= 1'b0;
         o_rf_en_r  <= 1'b0;
         o_rf_add   <= '0;
         o_rf_data  <= '0;
         o_tx_data  <= '0;
         o_tx_valid <= 1'b0;
         o_busy     <= 1'b0;
         o_err      <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         o_rf_en_w  <= rf_en_w_n;
         o_rf_en_r  <= rf_en_r_n;
         o_rf_add   <= rf_add_n;
         o_rf_data  <= rf_data_n;
         o_tx_data  <= tx_data_n;
         o_tx_valid <= tx_valid_n;
         o_busy     <= (state_n != IDLE);
         o_err      <= err_n;
      end
   end

   always_ff @(posedge i_clk) begin
      rd_byte <= rd_byte_n;
   end

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// Randomized scoreboard bench for regfile_cmd_ctrl: the bench plays UART and
// regfile, keeps a 16-entry memory model, and checks every DUT pulse.
module tb_regfile_cmd_ctrl;

   logic       clk;
   logic       i_rst;
   logic [7:0] i_rx_data;
   logic       i_rx_valid;
   logic       o_rf_en_w, o_rf_en_r;
   logic [3:0] o_rf_add;
   logic [7:0] o_rf_data;
   logic [7:0] i_rf_data;
   logic       i_rf_valid;
   logic [7:0] o_tx_data;
   logic       o_tx_valid;
   logic       i_tx_busy;
   logic       o_busy, o_err;

   regfile_cmd_ctrl dut (
      .i_clk(clk), .i_rst(i_rst),
      .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
      .o_rf_en_w(o_rf_en_w), .o_rf_en_r(o_rf_en_r),
      .o_rf_add(o_rf_add), .o_rf_data(o_rf_data),
      .i_rf_data(i_rf_data), .i_rf_valid(i_rf_valid),
      .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_busy(i_tx_busy),
      .o_busy(o_busy), .o_err(o_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   localparam int N_PAIRS = 2500;
   localparam int QD      = 4096;

   // Expected-event queues: stimulus owns the write index, monitor the read index.
   logic [3:0] wr_add_q [0:QD-1];
   logic [7:0] wr_dat_q [0:QD-1];
   logic [3:0] rd_add_q [0:QD-1];
   logic [7:0] tx_dat_q [0:QD-1];
   int         wr_n, rd_n, tx_n, err_issued, stim_timeouts;
   bit         stim_done;
   logic [7:0] model [0:15];
   int         rd_delay;
   bit         no_resp;

   // ---------------- stimulus ----------------
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      cycle();
      i_rx_valid = 1'b0;
      repeat (gap) cycle();
   endtask

   task automatic wait_idle();
      int n = 0;
      while (o_busy && n < 200) begin
         cycle();
         n++;
      end
      if (o_busy) begin
         stim_timeouts++;
         $display("FAIL wait_idle: o_busy=%0b after %0d cycles, required 0", o_busy, n);
      end
   endtask

   task automatic do_write(input logic [3:0] a, input logic [7:0] d, input int gap);
      model[a]         = d;
      wr_add_q[wr_n]   = a;
      wr_dat_q[wr_n]   = d;
      wr_n++;
      send_byte(8'hAA, gap);
      send_byte({4'h0, a}, gap);
      send_byte(d, gap);
   endtask

   task automatic do_read(input logic [3:0] a, input int delay, input int busy_cycles);
      rd_delay       = delay;
      rd_add_q[rd_n] = a;
      rd_n++;
      tx_dat_q[tx_n] = model[a];
      tx_n++;
      if (busy_cycles > 0) i_tx_busy = 1'b1;
      send_byte(8'hBB, 0);
      send_byte({4'h0, a}, 0);
      repeat (busy_cycles) cycle();
      i_tx_busy = 1'b0;
      wait_idle();
   endtask

   initial begin : stim
      logic [3:0] a, last_a;
      logic [7:0] d, b;
      i_rst = 1'b1; i_rx_data = '0; i_rx_valid = 1'b0; i_tx_busy = 1'b0;
      rd_delay = 0; no_resp = 1'b0; stim_done = 1'b0;
      wr_n = 0; rd_n = 0; tx_n = 0; err_issued = 0; stim_timeouts = 0;
      for (int k = 0; k < 16; k++) model[k] = '0;
      cycle(); cycle();
      i_rst = 1'b0;
      cycle();

      do_write(4'h3, 8'h5C, 0);
      do_read(4'h3, 2, 0);
      do_read(4'h3, 0, 10);

      err_issued++;
      send_byte(8'h11, 0);
      wait_idle();
      err_issued++;
      send_byte(8'hAA, 0);
      send_byte(8'h13, 0);
      wait_idle();

      // Read with no regfile response: only the strobe and a timeout error.
      no_resp = 1'b1;
      rd_add_q[rd_n] = 4'h7;
      rd_n++;
      err_issued++;
      send_byte(8'hBB, 0);
      send_byte(8'h07, 0);
      wait_idle();
      no_resp = 1'b0;

      // Reset lands together with the data byte of a write.
      send_byte(8'hAA, 0);
      send_byte(8'h05, 1);
      i_rx_data = 8'h77; i_rx_valid = 1'b1; i_rst = 1'b1;
      cycle();
      i_rx_valid = 1'b0;
      cycle();
      i_rst = 1'b0;
      cycle();

      last_a = 4'h3;
      for (int p = 0; p < N_PAIRS; p++) begin
         if ($urandom_range(0, 15) == 0) begin
            do b = 8'($urandom); while (b == 8'hAA || b == 8'hBB);
            err_issued++;
            send_byte(b, 0);
         end
         if ($urandom_range(0, 15) == 0) begin
            b = {4'($urandom_range(1, 15)), 4'($urandom)};
            err_issued++;
            send_byte(8'hAA, 0);
            send_byte(b, 0);
         end
         a = 4'($urandom);
         d = 8'($urandom);
         do_write(a, d, $urandom_range(0, 1));
         last_a = a;
         a = ($urandom_range(0, 1) == 0) ? last_a : 4'($urandom);
         do_read(a, $urandom_range(0, 4), $urandom_range(0, 3));
      end

      repeat (5) cycle();
      stim_done = 1'b1;
   end

   // ---------------- regfile responder ----------------
   initial begin : responder
      logic [7:0] rf_mem [0:15];
      bit         pend;
      int         pend_wait;
      logic [7:0] pend_data;
      for (int k = 0; k < 16; k++) rf_mem[k] = '0;
      i_rf_valid = 1'b0;
      i_rf_data  = '0;
      pend = 1'b0; pend_wait = 0; pend_data = '0;
      forever begin
         @(posedge clk);
         #1;
         i_rf_valid = 1'b0;
         if (o_rf_en_w) rf_mem[o_rf_add] = o_rf_data;
         if (pend) begin
            if (pend_wait == 0) begin
               i_rf_valid = 1'b1;
               i_rf_data  = pend_data;
               pend       = 1'b0;
            end else begin
               pend_wait--;
            end
         end
         if (o_rf_en_r && !no_resp) begin
            if (rd_delay == 0) begin
               i_rf_valid = 1'b1;
               i_rf_data  = rf_mem[o_rf_add];
            end else begin
               pend      = 1'b1;
               pend_wait = rd_delay - 1;
               pend_data = rf_mem[o_rf_add];
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   int checks, fails;

   task automatic check(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   initial begin : monitor
      int         wr_i, rd_i, tx_i, err_seen;
      bit         prev_rst, prev_rx_valid, prev_tx_busy;
      logic [7:0] last_tx_data;
      logic [24:0] outs;
      checks = 0; fails = 0;
      wr_i = 0; rd_i = 0; tx_i = 0; err_seen = 0;
      prev_rst = 1'b0; prev_rx_valid = 1'b0; prev_tx_busy = 1'b0;
      last_tx_data = '0;
      forever begin
         @(negedge clk);
         outs = {o_rf_en_w, o_rf_en_r, o_rf_add, o_rf_data, o_tx_data, o_tx_valid, o_busy, o_err};
         if (prev_rst) check(outs == '0, "reset_outputs", int'(outs), 0);
         if (o_rf_en_w) begin
            check(prev_rx_valid, "wr_strobe_follows_byte", int'(prev_rx_valid), 1);
            if (wr_i >= wr_n) check(1'b0, "unexpected_wr", {o_rf_add, o_rf_data}, 0);
            else begin
               check({o_rf_add, o_rf_data} == {wr_add_q[wr_i], wr_dat_q[wr_i]}, "wr_addr_data",
                     {o_rf_add, o_rf_data}, {wr_add_q[wr_i], wr_dat_q[wr_i]});
               wr_i++;
            end
         end
         if (o_rf_en_r) begin
            check(prev_rx_valid, "rd_strobe_follows_byte", int'(prev_rx_valid), 1);
            if (rd_i >= rd_n) check(1'b0, "unexpected_rd", o_rf_add, 0);
            else begin
               check(o_rf_add == rd_add_q[rd_i], "rd_addr", o_rf_add, rd_add_q[rd_i]);
               rd_i++;
            end
         end
         if (o_tx_valid) begin
            check(!prev_tx_busy, "tx_while_busy", int'(prev_tx_busy), 0);
            check(!o_busy, "busy_after_tx", int'(o_busy), 0);
            if (tx_i >= tx_n) check(1'b0, "unexpected_tx", o_tx_data, 0);
            else begin
               check(o_tx_data == tx_dat_q[tx_i], "tx_data", o_tx_data, tx_dat_q[tx_i]);
               tx_i++;
            end
         end else if (!prev_rst) begin
            check(o_tx_data == last_tx_data, "tx_data_hold", o_tx_data, last_tx_data);
         end
         if (o_err) begin
            check(err_seen < err_issued, "unexpected_err", err_seen + 1, err_issued);
            err_seen++;
         end
         prev_rst      = i_rst;
         prev_rx_valid = i_rx_valid;
         prev_tx_busy  = i_tx_busy;
         last_tx_data  = o_tx_data;
         if (stim_done) begin
            check(wr_i == wr_n, "wr_count", wr_i, wr_n);
            check(rd_i == rd_n, "rd_count", rd_i, rd_n);
            check(tx_i == tx_n, "tx_count", tx_i, tx_n);
            check(err_seen == err_issued, "err_count", err_seen, err_issued);
            check(stim_timeouts == 0, "idle_timeouts", stim_timeouts, 0);
            $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
            $finish;
         end
      end
   end

endmodule
